fpu_vfloat_req_queue: RTL and testbench
=======================================

// Module: fpu_vfloat_req_queue
// PURPOSE
//  Request issue queue in front of the VFloat FPU controller. Buffers CPU FP requests
//  {operator, rounding mode, tag, op1, op2} in a DEPTH-entry FIFO. Issues them one at a time
//  to the controller's in_valid/cpu_ready/fpu_ready handshake, with at most one op in flight.
//  Rejects illegal operator codes at enqueue, so the controller never hangs in BUSY.
// PARAMETERS
//  EXP_WIDTH     8    exponent bits
//  MAN_WIDTH     23   mantissa bits
//  IEEE_W        1+EXP_WIDTH+MAN_WIDTH (localparam) operand width
//  DEPTH         4    FIFO entries; power of two, >=2
//  LEGAL_OP_MAX  3'd4 highest legal operator code (0 ADD,1 SUB,2 MUL,3 DIV,4 SQRT)
// PORTS
//  clk            in   1        clock
//  reset          in   1        asynchronous, active-high
//  req_valid      in   1        CPU request valid
//  req_ready      out  1        queue can accept (push when req_valid&&req_ready)
//  req_operator   in   3        operator code
//  req_rm         in   3        rounding mode (passed through unmodified)
//  req_tag        in   4        request tag
//  req_op1        in   IEEE_W   operand 1
//  req_op2        in   IEEE_W   operand 2
//  flush          in   1        synchronous discard of all queued (not in-flight) entries
//  operator       out  3        to controller: head operator
//  rounding_mode  out  3        to controller: head rounding mode
//  tag            out  4        to controller: head tag
//  inOp1          out  IEEE_W   to controller: head op1
//  inOp2          out  IEEE_W   to controller: head op2
//  in_valid       out  1        to controller: head valid and issuable
//  cpu_ready      out  1        to controller: equals in_valid
//  fpu_ready      in   1        from controller: accepts request this cycle
//  result_valid   in   1        from controller: 1-cycle completion pulse
//  inflight       out  1        an issued op has not yet completed
//  count          out  $clog2(DEPTH+1)  queued entries
//  empty          out  1        count==0
//  full           out  1        count==DEPTH
//  err_valid      out  1        1-cycle pulse: illegal operator rejected
//  err_tag        out  4        tag of the rejected request
// BEHAVIOUR
//  Reset: FIFO storage, pointers and count cleared to 0; inflight=0, err_valid=0, err_tag=0.
//   Result: empty=1, full=0, in_valid=cpu_ready=0, head data outputs=0.
//  FIFO: wr/rd pointers are log2(DEPTH) bits and wrap naturally; head outputs read storage at rd_ptr.
//  req_ready = !full && !flush. No same-cycle bypass: when full, a pop does not open a push slot.
//  Push: req_valid&&req_ready with req_operator<=LEGAL_OP_MAX -> write at wr_ptr; wr_ptr++, count++.
//  Reject: req_valid&&req_ready with req_operator>LEGAL_OP_MAX -> not stored, count unchanged;
//   next cycle err_valid=1 and err_tag=req_tag.
//  Issue: in_valid = !empty && !inflight. Issue fires when in_valid && fpu_ready.
//   On issue: rd_ptr++, count--, inflight<=1 on the next edge.
//  Complete: result_valid -> inflight<=0. The next issue can occur in the cycle after result_valid.
//  Same-cycle push+issue: count unchanged, both pointers advance.
//  Same-cycle issue+result_valid: cannot occur, because in_valid=0 while inflight=1.
//  Flush (sync, 1 cycle): pointers and count -> 0 next edge. A push in that cycle is blocked.
//   An issue in the same cycle still completes and sets inflight.
//   inflight is unaffected, so the current op finishes normally.
//  Controller in S_INIT after reset holds fpu_ready=0; head simply waits.
//  Async reset mid-operation: queue and inflight cleared immediately; nothing replays.
//  Latency: an empty queue with a push at cycle N shows in_valid=1 at N+1.
// TESTING
//  T1 reset: assert reset mid-traffic -> count=0, empty=1, in_valid=0, inflight=0, err_valid=0.
//  T2 fill: push 4 ADDs (tags 1..4) with fpu_ready=0 -> full=1, req_ready=0, count=4;
//   a 5th req is held.
//  T3 issue order: fpu_ready=1 with a result_valid pulse 3 cycles after each issue
//   -> tags issue 1,2,3,4 in order; never 2 issues without an intervening result_valid.
//  T4 illegal: push operator=3'd6, tag=9 -> count unchanged, err_valid=1 for 1 cycle,
//   err_tag=9, op never reaches in_valid.
//  T5 flush: 3 queued + 1 inflight, flush=1 -> count=0 next cycle;
//   result_valid later clears inflight; push in flush cycle dropped.
//  T6 wrap: 10 push/issue cycles at DEPTH=4 with simultaneous push+issue
//   -> operands emerge bit-exact, in order; count stays consistent.

Source files
------------

// File: rtl/fpu_vfloat_req_queue.sv
// Request issue queue in front of the VFloat FPU controller.
// Buffers CPU floating-point requests in a small FIFO and hands them to the
// controller one at a time. At most one operation is ever in flight. Requests
// carrying an operator code the controller does not implement are dropped at
// enqueue and reported on err_valid/err_tag, so the controller never sits in
// BUSY waiting for an operation it cannot finish.
module fpu_vfloat_req_queue #(
  parameter int         EXP_WIDTH    = 8,
  parameter int         MAN_WIDTH    = 23,
  parameter int         DEPTH        = 4,
  parameter logic [2:0] LEGAL_OP_MAX = 3'd4,
  localparam int        IEEE_W       = 1 + EXP_WIDTH + MAN_WIDTH,
  localparam int        CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  // CPU request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_operator,
  input  logic [2:0]        req_rm,
  input  logic [3:0]        req_tag,
  input  logic [IEEE_W-1:0] req_op1,
  input  logic [IEEE_W-1:0] req_op2,
  input  logic              flush,
  // Controller side
  output logic [2:0]        operator,
  output logic [2:0]        rounding_mode,
  output logic [3:0]        tag,
  output logic [IEEE_W-1:0] inOp1,
  output logic [IEEE_W-1:0] inOp2,
  output logic              in_valid,
  output logic              cpu_ready,
  input  logic              fpu_ready,
  input  logic              result_valid,
  // Status
  output logic              inflight,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              err_valid,
  output logic [3:0]        err_tag
);

  localparam int PTR_W = $clog2(DEPTH);
  // Entry layout: {operator, rounding mode, tag, op1, op2}
  localparam int ENT_W = 3 + 3 + 4 + 2 * IEEE_W;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_inflight;
  logic             r_err_valid;
  logic [3:0]       r_err_tag;

  logic [ENT_W-1:0] w_entries [DEPTH];
  logic [ENT_W-1:0] w_wr_data;
  logic [ENT_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_legal;
  logic             w_push;
  logic             w_reject;
  logic             w_in_valid;
  logic             w_issue;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  // No bypass: a pop in the same cycle never opens a slot while full.
  assign w_req_ready = !w_full && !flush;
  assign w_accept    = req_valid && w_req_ready;
  assign w_legal     = (req_operator <= LEGAL_OP_MAX);
  assign w_push      = w_accept && w_legal;
  assign w_reject    = w_accept && !w_legal;
  // Hold the head back while an op is outstanding so only one is ever in flight.
  assign w_in_valid  = !w_empty && !r_inflight;
  assign w_issue     = w_in_valid && fpu_ready;
  assign w_wr_data   = {req_operator, req_rm, req_tag, req_op1, req_op2};

  // Storage: one register per entry so the whole queue clears on reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [ENT_W-1:0] r_entry;

    // Capture the request when the write pointer selects this slot
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_entry <= '0;
      end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
        r_entry <= w_wr_data;
      end
    end

    assign w_entries[gi] = r_entry;
  end

  assign w_head = w_entries[r_rd_ptr];

  // Pointers and occupancy; flush empties the queue but leaves storage intact
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // In-flight tracking: set on issue, cleared by the completion pulse; flush leaves it alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight <= 1'b1;
    end else if (result_valid) begin
      r_inflight <= 1'b0;
    end
  end

  // Illegal-operator report: one-cycle pulse, tag held until the next rejection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_valid <= 1'b0;
      r_err_tag   <= 4'd0;
    end else begin
      r_err_valid <= w_reject;
      if (w_reject) begin
        r_err_tag <= req_tag;
      end
    end
  end

  assign {operator, rounding_mode, tag, inOp1, inOp2} = w_head;
  assign in_valid  = w_in_valid;
  assign cpu_ready = w_in_valid;
  assign req_ready = w_req_ready;
  assign inflight  = r_inflight;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign err_valid = r_err_valid;
  assign err_tag   = r_err_tag;

endmodule

// File: tb/tb_fpu_vfloat_req_queue.sv
// Self-checking bench for fpu_vfloat_req_queue: a table of directed steps with
// hand-computed expected state, then hand-written wrap and async-reset sequences.
module tb_fpu_vfloat_req_queue;

  localparam int IEEE_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_operator;
  logic [2:0]        req_rm;
  logic [3:0]        req_tag;
  logic [IEEE_W-1:0] req_op1;
  logic [IEEE_W-1:0] req_op2;
  logic              flush;
  logic [2:0]        operator;
  logic [2:0]        rounding_mode;
  logic [3:0]        tag;
  logic [IEEE_W-1:0] inOp1;
  logic [IEEE_W-1:0] inOp2;
  logic              in_valid;
  logic              cpu_ready;
  logic              fpu_ready;
  logic              result_valid;
  logic              inflight;
  logic [2:0]        count;
  logic              empty;
  logic              full;
  logic              err_valid;
  logic [3:0]        err_tag;

  fpu_vfloat_req_queue dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_operator (req_operator),
    .req_rm       (req_rm),
    .req_tag      (req_tag),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .flush        (flush),
    .operator     (operator),
    .rounding_mode(rounding_mode),
    .tag          (tag),
    .inOp1        (inOp1),
    .inOp2        (inOp2),
    .in_valid     (in_valid),
    .cpu_ready    (cpu_ready),
    .fpu_ready    (fpu_ready),
    .result_valid (result_valid),
    .inflight     (inflight),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .err_valid    (err_valid),
    .err_tag      (err_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [3:0] t;
    logic       fl;
    logic       fr;
    logic       rv;
    logic [2:0] e_cnt;
    logic       e_empty;
    logic       e_full;
    logic       e_inv;
    logic       e_inf;
    logic       e_err;
    logic [3:0] e_errtag;
    logic       chk_head;
    logic [3:0] e_head;
    logic [2:0] e_hop;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] sb_op1 [$];
  logic [31:0] sb_op2 [$];
  logic [3:0]  sb_tag [$];

  function automatic vec_t mk(
    input logic v, input logic [2:0] op, input logic [3:0] t,
    input logic fl, input logic fr, input logic rv,
    input logic [2:0] cnt, input logic emp, input logic ful, input logic inv,
    input logic inf, input logic err, input logic [3:0] errtag,
    input logic chk, input logic [3:0] head, input logic [2:0] hop);
    vec_t r;
    r.v = v; r.op = op; r.t = t; r.fl = fl; r.fr = fr; r.rv = rv;
    r.e_cnt = cnt; r.e_empty = emp; r.e_full = ful; r.e_inv = inv;
    r.e_inf = inf; r.e_err = err; r.e_errtag = errtag;
    r.chk_head = chk; r.e_head = head; r.e_hop = hop;
    return r;
  endfunction

  function automatic logic [31:0] op1_of(input logic [3:0] t);
    return 32'h3F80_0000 | {28'h0, t};
  endfunction

  function automatic logic [31:0] op2_of(input logic [3:0] t);
    return {t, 28'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_operator = 3'd0; req_rm = 3'd0; req_tag = 4'd0;
    req_op1 = '0; req_op2 = '0; flush = 1'b0; fpu_ready = 1'b0; result_valid = 1'b0;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [3:0] t);
    req_valid = 1'b1; req_operator = op; req_rm = t[2:0]; req_tag = t;
    req_op1 = op1_of(t); req_op2 = op2_of(t);
  endtask

  task automatic check_vec(input int idx);
    vec_t e;
    logic ok;
    e = vecs[idx];
    ok = (count == e.e_cnt) && (empty == e.e_empty) && (full == e.e_full) &&
         (in_valid == e.e_inv) && (cpu_ready == e.e_inv) && (inflight == e.e_inf) &&
         (err_valid == e.e_err) && (err_tag == e.e_errtag) && (req_ready == !e.e_full);
    if (e.chk_head) begin
      ok = ok && (tag == e.e_head) && (operator == e.e_hop) &&
           (rounding_mode == e.e_head[2:0]) && (inOp1 == op1_of(e.e_head)) &&
           (inOp2 == op2_of(e.e_head));
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got cnt=%0d emp=%0b full=%0b inv=%0b cpur=%0b inf=%0b err=%0b etag=%0d rdy=%0b tag=%0d op=%0d rm=%0d op1=%h op2=%h | need cnt=%0d emp=%0b full=%0b inv=%0b inf=%0b err=%0b etag=%0d head=%0d(chk=%0b) hop=%0d",
               idx, count, empty, full, in_valid, cpu_ready, inflight, err_valid, err_tag,
               req_ready, tag, operator, rounding_mode, inOp1, inOp2,
               e.e_cnt, e.e_empty, e.e_full, e.e_inv, e.e_inf, e.e_err, e.e_errtag,
               e.e_head, e.chk_head, e.e_hop);
    end else begin
      $display("vec%0d ok: cnt=%0d inv=%0b inf=%0b tag=%0d", idx, count, in_valid, inflight, tag);
    end
  endtask

  task automatic check(input string name, input logic cond, input logic [63:0] got, input logic [63:0] need);
    n_vec++;
    if (!cond) begin
      n_bad++;
      $display("FAIL %s: got %h need %h", name, got, need);
    end else begin
      $display("%s ok: %h", name, got);
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  nt;

    //           v op  tag fl fr rv | cnt emp ful inv inf err etag chk head hop
    vecs[0]  = mk(0, 0, 0, 0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  0);
    vecs[1]  = mk(1, 0, 1, 0, 0, 0,   1,  0,  0,  1,  0,  0,  0,  1,  1,  0);
    vecs[2]  = mk(1, 0, 2, 0, 0, 0,   2,  0,  0,  1,  0,  0,  0,  1,  1,  0);
    vecs[3]  = mk(1, 0, 3, 0, 0, 0,   3,  0,  0,  1,  0,  0,  0,  1,  1,  0);
    vecs[4]  = mk(1, 0, 4, 0, 0, 0,   4,  0,  1,  1,  0,  0,  0,  1,  1,  0);
    vecs[5]  = mk(1, 0, 5, 0, 0, 0,   4,  0,  1,  1,  0,  0,  0,  1,  1,  0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 0,   3,  0,  0,  0,  1,  0,  0,  1,  2,  0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 0,   3,  0,  0,  0,  1,  0,  0,  1,  2,  0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1,   3,  0,  0,  1,  0,  0,  0,  1,  2,  0);
    vecs[9]  = mk(1, 6, 9, 0, 0, 0,   3,  0,  0,  1,  0,  1,  9,  1,  2,  0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0,   3,  0,  0,  1,  0,  0,  9,  1,  2,  0);
    vecs[11] = mk(1, 0, 5, 0, 1, 0,   3,  0,  0,  0,  1,  0,  9,  1,  3,  0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1,   3,  0,  0,  1,  0,  0,  9,  1,  3,  0);
    vecs[13] = mk(1, 1, 6, 1, 1, 0,   0,  1,  0,  0,  1,  0,  9,  0,  0,  0);
    vecs[14] = mk(1, 2, 7, 0, 0, 0,   1,  0,  0,  0,  1,  0,  9,  1,  7,  2);
    vecs[15] = mk(0, 0, 0, 0, 0, 1,   1,  0,  0,  1,  0,  0,  9,  1,  7,  2);
    vecs[16] = mk(0, 0, 0, 0, 1, 0,   0,  1,  0,  0,  1,  0,  9,  0,  0,  0);
    vecs[17] = mk(0, 0, 0, 0, 0, 1,   0,  1,  0,  0,  0,  0,  9,  0,  0,  0);

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // Flush blocks acceptance combinationally
    flush = 1'b1;
    #1;
    check("flush_blocks_ready", req_ready == 1'b0, 64'(req_ready), 64'd0);
    flush = 1'b0;
    #1;
    check("ready_after_flush", req_ready == 1'b1, 64'(req_ready), 64'd1);

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      idle();
      if (vecs[i].v) drive_req(vecs[i].op, vecs[i].t);
      flush        = vecs[i].fl;
      fpu_ready    = vecs[i].fr;
      result_valid = vecs[i].rv;
      tick();
      idle();
      #1;
      check_vec(i);
    end

    // Wrap: simultaneous push+issue with random operands, order checked via scoreboard
    a = $urandom; b = $urandom; nt = 4'd1;
    drive_req(3'd0, nt); req_op1 = a; req_op2 = b;
    tick();
    idle();
    sb_op1.push_back(a); sb_op2.push_back(b); sb_tag.push_back(nt);
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; nt = 4'(i + 2);
      drive_req(3'(i % 5), nt); req_op1 = a; req_op2 = b;
      fpu_ready = 1'b1;
      #1;
      check($sformatf("wrap_head%0d", i),
            in_valid && (tag == sb_tag[0]) && (inOp1 == sb_op1[0]) && (inOp2 == sb_op2[0]),
            {inOp1, inOp2}, {sb_op1[0], sb_op2[0]});
      tick();
      idle();
      void'(sb_op1.pop_front()); void'(sb_op2.pop_front()); void'(sb_tag.pop_front());
      sb_op1.push_back(a); sb_op2.push_back(b); sb_tag.push_back(nt);
      #1;
      check($sformatf("wrap_count%0d", i), (count == 3'd1) && inflight,
            {60'd0, inflight, count}, {60'd0, 1'b1, 3'd1});
      result_valid = 1'b1;
      tick();
      idle();
    end
    fpu_ready = 1'b1;
    #1;
    check("wrap_last", in_valid && (tag == sb_tag[0]) && (inOp1 == sb_op1[0]) && (inOp2 == sb_op2[0]),
          {inOp1, inOp2}, {sb_op1[0], sb_op2[0]});
    tick();
    idle();
    result_valid = 1'b1;
    tick();
    idle();
    #1;
    check("wrap_drained", empty && !inflight && !in_valid,
          {61'd0, empty, inflight, in_valid}, {61'd0, 1'b1, 1'b0, 1'b0});

    // Asynchronous reset mid-traffic
    drive_req(3'd3, 4'd1); tick(); idle();
    drive_req(3'd3, 4'd2); tick(); idle();
    fpu_ready = 1'b1; tick(); idle();
    drive_req(3'd7, 4'd9); tick(); idle();
    #1;
    check("pre_reset", (count == 3'd1) && inflight && err_valid && (err_tag == 4'd9),
          {56'd0, count, inflight, err_valid, 1'b0, 2'd0}, {56'd0, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0});
    reset = 1'b1;
    #1;
    check("async_reset", (count == 3'd0) && empty && !full && !in_valid && !cpu_ready &&
          !inflight && !err_valid && (err_tag == 4'd0) && (tag == 4'd0) && (inOp1 == 32'd0) &&
          (inOp2 == 32'd0) && (operator == 3'd0),
          {count, empty, full, in_valid, inflight, err_valid, err_tag, tag, inOp1, 13'd0},
          {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 13'd0});
    #1;
    reset = 1'b0;
    tick();
    #1;
    check("no_replay", (count == 3'd0) && !inflight && !in_valid,
          {61'd0, count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
